multicycle_controller: RTL and testbench

Parametrised multi-cycle successor to the single-cycle RV32I controller. It decodes the instruction register and sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states. It drives datapath enables and mux selects, and handshakes with instruction and data memories that may take several cycles to respond. It sits between the shared datapath (PC, IR, register file, ALU, branch comparator) and the memories, and adds a retired-instruction counter, memory timeouts and a sticky trap.

---
 rtl/multicycle_controller.sv | 259 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with
// multi-cycle instruction/data memories, counts retired instructions and traps sticky.
module multicycle_controller #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             reg_wr,
    output logic             sel_A,
    output logic             sel_B,
    output logic [3:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic [2:0]       br_type,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_R, C_ALU_I, C_LUI, C_AUIPC, C_BRANCH,
        C_JAL, C_JALR, C_LOAD, C_STORE, C_ILLEGAL
    } iclass_t;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [2:0] BR_NEVER  = 3'b010;
    localparam logic [2:0] BR_ALWAYS = 3'b011;

    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state, state_next;
    iclass_t           cls;
    logic              run;
    logic [WCNT_W-1:0] wait_cnt;
    logic              waiting, timed_out;
    logic [1:0]        cause_next;
    logic              reg_wr_raw;
    logic [3:0]        dec_alu;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign rd          = inst[11:7];
    assign funct3      = inst[14:12];
    assign funct7      = inst[31:25];
    assign unused_bits = &{1'b0, br_taken, inst[24:15]};

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_of = ALU_SLL;
            3'b010:  alu_of = ALU_SLT;
            3'b011:  alu_of = ALU_SLTU;
            3'b100:  alu_of = ALU_XOR;
            3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    // Instruction classification; anything not listed here is illegal.
    always_comb begin
        cls     = C_ILLEGAL;
        dec_alu = ALU_ADD;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    cls = C_ALU_R;
                dec_alu = alu_of(funct3, funct7[5]);
            end
            7'b0010011: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) cls = C_ALU_I;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) cls = C_ALU_I;
                end else begin
                    cls = C_ALU_I;
                end
                dec_alu = alu_of(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            7'b0110111: begin
                cls     = C_LUI;
                dec_alu = ALU_PASS_B;
            end
            7'b0010111: cls = C_AUIPC;
            7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) cls = C_BRANCH;
            7'b1101111: cls = C_JAL;
            7'b1100111: if (funct3 == 3'b000) cls = C_JALR;
            7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) cls = C_LOAD;
            7'b0100011: if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) cls = C_STORE;
            default:    cls = C_ILLEGAL;
        endcase
    end

    // Timeout fires when the registered count already equals TIMEOUT and ready is still low.
    assign waiting   = (state == S_FETCH && run && !imem_ready) || (state == S_MEM && !dmem_ready);
    assign timed_out = (TIMEOUT > 0) && (wait_cnt == WCNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            run        <= 1'b0;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
            instret    <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && !timed_out)
                wait_cnt <= wait_cnt + WCNT_W'(1);
            if (state_next == S_TRAP && state != S_TRAP)
                trap_cause <= cause_next;
            if (pc_wr)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        cause_next = 2'd0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        reg_wr_raw = 1'b0;
        sel_A      = 1'b0;
        sel_B      = 1'b0;
        alu_op     = ALU_ADD;
        wb_sel     = 2'd0;
        br_type    = 3'b000;
        case (state)
            S_FETCH: begin
                if (run) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_wr      = 1'b1;
                        state_next = S_DECODE;
                    end else if (timed_out) begin
                        state_next = S_TRAP;
                        cause_next = 2'd2;
                    end
                end
            end
            S_DECODE: begin
                if (cls == C_ILLEGAL) begin
                    state_next = S_TRAP;
                    cause_next = 2'd1;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op     = dec_alu;
                br_type    = BR_NEVER;
                state_next = S_FETCH;
                case (cls)
                    C_ALU_R: begin
                        reg_wr_raw = 1'b1;
                        pc_wr      = 1'b1;
                    end
                    C_ALU_I, C_LUI: begin
                        sel_B      = 1'b1;
                        reg_wr_raw = 1'b1;
                        pc_wr      = 1'b1;
                    end
                    C_AUIPC: begin
                        sel_A      = 1'b1;
                        sel_B      = 1'b1;
                        reg_wr_raw = 1'b1;
                        pc_wr      = 1'b1;
                    end
                    C_BRANCH: begin
                        sel_A   = 1'b1;
                        sel_B   = 1'b1;
                        br_type = funct3;
                        pc_wr   = 1'b1;
                    end
                    C_JAL, C_JALR: begin
                        sel_A      = (cls == C_JAL);
                        sel_B      = 1'b1;
                        wb_sel     = 2'd2;
                        reg_wr_raw = 1'b1;
                        br_type    = BR_ALWAYS;
                        pc_wr      = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        sel_B      = 1'b1;
                        state_next = S_MEM;
                    end
                    default: begin
                        state_next = S_TRAP;
                        cause_next = 2'd1;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_STORE);
                sel_B    = 1'b1;
                br_type  = BR_NEVER;
                if (dmem_ready) begin
                    if (cls == C_STORE) begin
                        pc_wr      = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = 2'd3;
                end
            end
            S_WB: begin
                reg_wr_raw = 1'b1;
                wb_sel     = 2'd1;
                pc_wr      = 1'b1;
                br_type    = BR_NEVER;
                state_next = S_FETCH;
            end
            default: state_next = S_TRAP;
        endcase
    end

    assign reg_wr = reg_wr_raw && (rd != 5'd0);
    assign trap   = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a cycle-by-cycle vector table for normal
// instruction flow, then hand sequences for traps, timeouts, async reset and counter wrap.
module tb_multicycle_controller;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] SW   = 32'h0020A223;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] JAL1 = 32'h010000EF;
    localparam logic [31:0] JAL0 = 32'h0100006F;
    localparam logic [31:0] SUB  = 32'h402081B3;
    localparam logic [31:0] LUI  = 32'h123452B7;
    localparam logic [31:0] SRAI = 32'h4030D213;
    localparam logic [31:0] ILL  = 32'hFFFFFFFF;
    localparam logic [2:0]  NEV  = 3'b010;
    localparam logic [2:0]  ALW  = 3'b011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst = '0;
    logic        br_taken = 1'b1;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;

    logic        imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, sel_A, sel_B, trap;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel, trap_cause;
    logic [2:0]  br_type;
    logic [3:0]  instret;

    logic        z_imem_req, z_dmem_req, z_dmem_we, z_ir_wr, z_pc_wr, z_reg_wr, z_sel_A, z_sel_B, z_trap;
    logic [3:0]  z_alu_op;
    logic [1:0]  z_wb_sel, z_trap_cause;
    logic [2:0]  z_br_type;
    logic [31:0] z_instret;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .inst(inst), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_wr(ir_wr),
        .pc_wr(pc_wr), .reg_wr(reg_wr), .sel_A(sel_A), .sel_B(sel_B), .alu_op(alu_op),
        .wb_sel(wb_sel), .br_type(br_type), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    multicycle_controller dut0 (
        .clk(clk), .reset(reset), .inst(inst), .br_taken(br_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(z_imem_req), .dmem_req(z_dmem_req), .dmem_we(z_dmem_we), .ir_wr(z_ir_wr),
        .pc_wr(z_pc_wr), .reg_wr(z_reg_wr), .sel_A(z_sel_A), .sel_B(z_sel_B), .alu_op(z_alu_op),
        .wb_sel(z_wb_sel), .br_type(z_br_type), .trap(z_trap), .trap_cause(z_trap_cause),
        .instret(z_instret)
    );

    // en = {imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, sel_A, sel_B}
    typedef struct packed {
        logic [7:0] en;
        logic [3:0] alu;
        logic [1:0] wb;
        logic [2:0] br;
        logic       trp;
        logic [1:0] cause;
        logic [3:0] cnt;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        ir;
        logic        dr;
        outs_t       exp;
    } vec_t;

    vec_t  vecs[$];
    outs_t got;

    assign got = outs_t'({imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, sel_A, sel_B,
                          alu_op, wb_sel, br_type, trap, trap_cause, instret});

    function automatic outs_t mk(input logic [7:0] en, input logic [3:0] alu, input logic [1:0] wb,
                                 input logic [2:0] br, input logic trp, input logic [1:0] cause,
                                 input logic [3:0] cnt);
        return outs_t'({en, alu, wb, br, trp, cause, cnt});
    endfunction

    function automatic void addVec(input string nm, input logic [31:0] i, input logic ir, input logic dr,
                                   input logic [7:0] en, input logic [3:0] alu, input logic [1:0] wb,
                                   input logic [2:0] br, input logic [3:0] cnt);
        vec_t v;
        v.name = nm;
        v.inst = i;
        v.ir   = ir;
        v.dr   = dr;
        v.exp  = mk(en, alu, wb, br, 1'b0, 2'd0, cnt);
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [31:0] i, input logic ir, input logic dr);
        @(negedge clk);
        reset      = 1'b1;
        inst       = i;
        imem_ready = ir;
        dmem_ready = dr;
        #1;
    endtask

    task automatic checkOutput(input string nm, input outs_t exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: outputs got %h expected %h", nm, got, exp);
        else
            passCount++;
    endtask

    task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            passCount++;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset      = 1'b0;
        inst       = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        checkOutput("reset_state", '0);
        checkVal("reset_state_wide", z_instret, 32'd0);
    endtask

    initial begin
        int bad;

        // One entry per clock cycle, starting with the cycle in which reset is released.
        addVec("release",     ADDI, 1, 1, 8'b0000_0000, 0, 0, 3'b000, 0);
        addVec("addi_fetch",  ADDI, 1, 1, 8'b1001_0000, 0, 0, 3'b000, 0);
        addVec("addi_decode", ADDI, 1, 1, 8'b0000_0000, 0, 0, 3'b000, 0);
        addVec("addi_exec",   ADDI, 1, 1, 8'b0000_1101, 0, 0, NEV, 0);
        addVec("lw_fetch",    LW,   1, 1, 8'b1001_0000, 0, 0, 3'b000, 1);
        addVec("lw_decode",   LW,   1, 1, 8'b0000_0000, 0, 0, 3'b000, 1);
        addVec("lw_exec",     LW,   1, 1, 8'b0000_0001, 0, 0, NEV, 1);
        addVec("lw_wait1",    LW,   1, 0, 8'b0100_0001, 0, 0, NEV, 1);
        addVec("lw_wait2",    LW,   1, 0, 8'b0100_0001, 0, 0, NEV, 1);
        addVec("lw_wait3",    LW,   1, 0, 8'b0100_0001, 0, 0, NEV, 1);
        addVec("lw_mem_done", LW,   1, 1, 8'b0100_0001, 0, 0, NEV, 1);
        addVec("lw_wb",       LW,   1, 1, 8'b0000_1100, 0, 1, NEV, 1);
        addVec("sw_fetch",    SW,   1, 1, 8'b1001_0000, 0, 0, 3'b000, 2);
        addVec("sw_decode",   SW,   1, 1, 8'b0000_0000, 0, 0, 3'b000, 2);
        addVec("sw_exec",     SW,   1, 1, 8'b0000_0001, 0, 0, NEV, 2);
        addVec("sw_mem",      SW,   1, 1, 8'b0110_1001, 0, 0, NEV, 2);
        addVec("beq_fetch",   BEQ,  1, 1, 8'b1001_0000, 0, 0, 3'b000, 3);
        addVec("beq_decode",  BEQ,  1, 1, 8'b0000_0000, 0, 0, 3'b000, 3);
        addVec("beq_exec",    BEQ,  1, 1, 8'b0000_1011, 0, 0, 3'b000, 3);
        addVec("jal1_fetch",  JAL1, 1, 1, 8'b1001_0000, 0, 0, 3'b000, 4);
        addVec("jal1_decode", JAL1, 1, 1, 8'b0000_0000, 0, 0, 3'b000, 4);
        addVec("jal1_exec",   JAL1, 1, 1, 8'b0000_1111, 0, 2, ALW, 4);
        addVec("jal0_fetch",  JAL0, 1, 1, 8'b1001_0000, 0, 0, 3'b000, 5);
        addVec("jal0_decode", JAL0, 1, 1, 8'b0000_0000, 0, 0, 3'b000, 5);
        addVec("jal0_exec",   JAL0, 1, 1, 8'b0000_1011, 0, 2, ALW, 5);
        addVec("sub_fetch",   SUB,  1, 1, 8'b1001_0000, 0, 0, 3'b000, 6);
        addVec("sub_decode",  SUB,  1, 1, 8'b0000_0000, 0, 0, 3'b000, 6);
        addVec("sub_exec",    SUB,  1, 1, 8'b0000_1100, 1, 0, NEV, 6);
        addVec("lui_fetch",   LUI,  1, 1, 8'b1001_0000, 0, 0, 3'b000, 7);
        addVec("lui_decode",  LUI,  1, 1, 8'b0000_0000, 0, 0, 3'b000, 7);
        addVec("lui_exec",    LUI,  1, 1, 8'b0000_1101, 10, 0, NEV, 7);
        addVec("srai_fetch",  SRAI, 1, 1, 8'b1001_0000, 0, 0, 3'b000, 8);
        addVec("srai_decode", SRAI, 1, 1, 8'b0000_0000, 0, 0, 3'b000, 8);
        addVec("srai_exec",   SRAI, 1, 1, 8'b0000_1101, 7, 0, NEV, 8);

        $display("[TB] vector table: %0d cycles", vecs.size());
        doReset();
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].inst, vecs[k].ir, vecs[k].dr);
            checkOutput(vecs[k].name, vecs[k].exp);
        end
        applyStimulus(ADDI, 1'b0, 1'b1);
        checkOutput("after_srai_fetch", mk(8'b1000_0000, 0, 0, 3'b000, 0, 0, 9));

        // Illegal instruction traps after DECODE and holds until reset.
        doReset();
        applyStimulus(ILL, 1'b1, 1'b1);
        applyStimulus(ILL, 1'b1, 1'b1);
        checkOutput("ill_fetch", mk(8'b1001_0000, 0, 0, 3'b000, 0, 0, 0));
        applyStimulus(ILL, 1'b1, 1'b1);
        checkOutput("ill_decode", mk(8'b0, 0, 0, 3'b000, 0, 0, 0));
        applyStimulus(ILL, 1'b1, 1'b1);
        checkOutput("ill_trap", mk(8'b0, 0, 0, 3'b000, 1, 1, 0));
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            applyStimulus((c % 2 == 0) ? ILL : ADDI, 1'b1, 1'b1);
            if (got !== mk(8'b0, 0, 0, 3'b000, 1, 1, 0)) bad++;
        end
        checkVal("ill_trap_hold_100", bad, 0);
        doReset();

        // Instruction fetch timeout: four low-ready cycles, then a fifth with count at limit.
        applyStimulus(ADDI, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(ADDI, 1'b0, 1'b0);
            checkOutput($sformatf("imem_wait%0d", c + 1), mk(8'b1000_0000, 0, 0, 3'b000, 0, 0, 0));
        end
        applyStimulus(ADDI, 1'b0, 1'b0);
        checkOutput("imem_timeout_trap", mk(8'b0, 0, 0, 3'b000, 1, 2, 0));
        checkVal("no_timeout_disabled_trap", {31'd0, z_trap}, 32'd0);
        checkVal("no_timeout_disabled_req", {31'd0, z_imem_req}, 32'd1);

        // Ready arriving with the counter at the limit still completes the fetch.
        doReset();
        applyStimulus(ADDI, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus(ADDI, 1'b0, 1'b0);
        applyStimulus(ADDI, 1'b1, 1'b0);
        checkOutput("fetch_at_limit", mk(8'b1001_0000, 0, 0, 3'b000, 0, 0, 0));
        applyStimulus(ADDI, 1'b1, 1'b0);
        checkOutput("decode_after_late_fetch", mk(8'b0, 0, 0, 3'b000, 0, 0, 0));
        applyStimulus(ADDI, 1'b1, 1'b0);
        checkOutput("exec_after_late_fetch", mk(8'b0000_1101, 0, 0, NEV, 0, 0, 0));

        // Data memory timeout on a load: no writeback, no retirement.
        applyStimulus(LW, 1'b1, 1'b0);
        applyStimulus(LW, 1'b1, 1'b0);
        applyStimulus(LW, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) applyStimulus(LW, 1'b1, 1'b0);
        checkOutput("dmem_last_wait", mk(8'b0100_0001, 0, 0, NEV, 0, 0, 1));
        applyStimulus(LW, 1'b1, 1'b1);
        checkOutput("dmem_timeout_trap", mk(8'b0, 0, 0, 3'b000, 1, 3, 1));
        checkVal("dmem_disabled_still_req", {31'd0, z_dmem_req}, 32'd1);

        // Asynchronous reset in the middle of a store's memory phase.
        doReset();
        applyStimulus(ADDI, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(ADDI, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(SW, 1'b1, 1'b0);
        applyStimulus(SW, 1'b1, 1'b0);
        checkOutput("sw_mem_wait", mk(8'b0110_0001, 0, 0, NEV, 0, 0, 1));
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset_mid_mem", '0);

        // Sixteen retirements wrap the 4-bit counter.
        applyStimulus(ADDI, 1'b1, 1'b1);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 3; c++) applyStimulus(ADDI, 1'b1, 1'b1);
        applyStimulus(ADDI, 1'b1, 1'b1);
        checkVal("instret_15", {28'd0, instret}, 32'd15);
        applyStimulus(ADDI, 1'b1, 1'b1);
        applyStimulus(ADDI, 1'b1, 1'b1);
        applyStimulus(ADDI, 1'b1, 1'b1);
        checkOutput("instret_wrap", mk(8'b1001_0000, 0, 0, 3'b000, 0, 0, 0));
        checkVal("instret_wide_16", z_instret, 32'd16);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
